// File: rtl/cond_flag_unit_pkg.sv
// ---------------------------------------------------------------------------
// cond_flag_unit_pkg
//   Shared definitions for the condition/flag unit and its consumers:
//   - cond_e     : the sixteen ARM-style condition codes
//   - *_IDX      : bit positions of N, Z, C, V inside a 4-bit NZCV vector
//   - FLAG_W_*   : masks selecting which flag pairs an instruction updates
// ---------------------------------------------------------------------------
package cond_flag_unit_pkg;

    typedef enum logic [3:0] {
        COND_EQ = 4'h0,  // Z
        COND_NE = 4'h1,  // !Z
        COND_CS = 4'h2,  // C
        COND_CC = 4'h3,  // !C
        COND_MI = 4'h4,  // N
        COND_PL = 4'h5,  // !N
        COND_VS = 4'h6,  // V
        COND_VC = 4'h7,  // !V
        COND_HI = 4'h8,  // C & !Z
        COND_LS = 4'h9,  // !C | Z
        COND_GE = 4'hA,  // N == V
        COND_LT = 4'hB,  // N != V
        COND_GT = 4'hC,  // !Z & (N == V)
        COND_LE = 4'hD,  // Z | (N != V)
        COND_AL = 4'hE,  // always
        COND_NV = 4'hF   // illegal encoding, never passes
    } cond_e;

    localparam int N_IDX = 3;
    localparam int Z_IDX = 2;
    localparam int C_IDX = 1;
    localparam int V_IDX = 0;

    // flag_w bit masks: upper bit updates the N/Z pair, lower bit the C/V pair
    localparam logic [1:0] FLAG_W_NZ = 2'b10;
    localparam logic [1:0] FLAG_W_CV = 2'b01;

endpackage : cond_flag_unit_pkg

// File: rtl/cond_flag_unit_if.sv
// ---------------------------------------------------------------------------
// cond_flag_unit_if
//   Bundles the execute-stage request (from decoder/ALU) and the writeback
//   results of the condition/flag unit.
//   Modports:
//     master : the decoder/ALU side; drives the execute-stage inputs and
//              observes writeback results, condition pass, flags, counters
//     slave  : the condition/flag unit itself
// ---------------------------------------------------------------------------
interface cond_flag_unit_if #(
    parameter int CNT_W = 16
);
    // execute-stage request
    logic             valid_in;
    logic             stall;
    logic             flush;
    logic [3:0]       cond;
    logic [3:0]       alu_flags;
    logic [1:0]       flag_w;
    logic             pcs_in;
    logic             reg_w_in;
    logic             mem_w_in;
    logic             no_write_in;

    // writeback-stage results and status
    logic             valid_o;
    logic             pcs_o;
    logic             reg_w_o;
    logic             mem_w_o;
    logic             cond_ex_o;
    logic             illegal_o;
    logic [3:0]       flags_o;
    logic [CNT_W-1:0] exec_cnt;
    logic [CNT_W-1:0] skip_cnt;

    modport master (
        output valid_in, stall, flush, cond, alu_flags, flag_w,
               pcs_in, reg_w_in, mem_w_in, no_write_in,
        input  valid_o, pcs_o, reg_w_o, mem_w_o, cond_ex_o, illegal_o,
               flags_o, exec_cnt, skip_cnt
    );

    modport slave (
        input  valid_in, stall, flush, cond, alu_flags, flag_w,
               pcs_in, reg_w_in, mem_w_in, no_write_in,
        output valid_o, pcs_o, reg_w_o, mem_w_o, cond_ex_o, illegal_o,
               flags_o, exec_cnt, skip_cnt
    );

endinterface : cond_flag_unit_if

// File: rtl/cond_flag_unit_cond_check.sv
// ---------------------------------------------------------------------------
// cond_flag_unit_cond_check
//   Purely combinational condition evaluator: given a 4-bit condition field
//   and an NZCV flag vector, reports whether the instruction should execute.
//   Ports:
//     cond  in  4  condition field (cond_e encoding)
//     flags in  4  NZCV flags, [3]=N [2]=Z [1]=C [0]=V
//     pass  out 1  condition satisfied
// ---------------------------------------------------------------------------
module cond_flag_unit_cond_check
    import cond_flag_unit_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       pass
);

    logic n, z, c, v;

    assign n = flags[N_IDX];
    assign z = flags[Z_IDX];
    assign c = flags[C_IDX];
    assign v = flags[V_IDX];

    always_comb begin
        // NOTE: every output of a combinational block gets a default before
        // the case so that no path leaves it unassigned (which infers a latch).
        pass = 1'b0;
        case (cond_e'(cond))
            COND_EQ: pass = z;
            COND_NE: pass = !z;
            COND_CS: pass = c;
            COND_CC: pass = !c;
            COND_MI: pass = n;
            COND_PL: pass = !n;
            COND_VS: pass = v;
            COND_VC: pass = !v;
            COND_HI: pass = c && !z;
            COND_LS: pass = !c || z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = !z && (n == v);
            COND_LE: pass = z || (n != v);
            COND_AL: pass = 1'b1;
            COND_NV: pass = 1'b0;
            default: pass = 1'b0;
        endcase
    end

endmodule : cond_flag_unit_cond_check

// File: rtl/cond_flag_unit.sv
// ---------------------------------------------------------------------------
// cond_flag_unit
//   Consumer side of the ALU flag interface. Holds the architectural NZCV
//   flags, evaluates the condition of the execute-stage instruction against
//   them, gates the instruction's write enables, registers them into the
//   writeback stage, and counts executed vs. squashed-by-condition
//   instructions.
//   Ports:
//     clk    in     system clock, rising edge
//     rst_n  in     asynchronous active-low reset
//     bus    slave  execute-stage request / writeback results
//                   (see cond_flag_unit_if)
//   Parameters:
//     CNT_W  width of exec_cnt / skip_cnt (wrap-around counters)
// ---------------------------------------------------------------------------
module cond_flag_unit
    import cond_flag_unit_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    cond_flag_unit_if.slave   bus
);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [3:0]       flags_q;
    logic             valid_q;
    logic             pcs_q;
    logic             reg_w_q;
    logic             mem_w_q;
    logic             illegal_q;
    logic [CNT_W-1:0] exec_q;
    logic [CNT_W-1:0] skip_q;

    // -----------------------------------------------------------------------
    // Condition evaluation against the registered flags. Because the check
    // looks at flags_q, an instruction's own flag write only becomes visible
    // to the instruction behind it.
    // -----------------------------------------------------------------------
    logic pass;

    cond_flag_unit_cond_check u_cond_check (
        .cond  (bus.cond),
        .flags (flags_q),
        .pass  (pass)
    );

    logic accept;
    logic wr_nz;
    logic wr_cv;
    logic illegal;

    assign accept  = bus.valid_in && !bus.stall && !bus.flush;
    assign wr_nz   = accept && pass && ((bus.flag_w & FLAG_W_NZ) != 2'b00);
    assign wr_cv   = accept && pass && ((bus.flag_w & FLAG_W_CV) != 2'b00);
    assign illegal = (bus.cond == COND_NV);

    // -----------------------------------------------------------------------
    // Architectural flags: N/Z and C/V pairs update independently; a pair
    // whose write enable is clear keeps its previous value.
    // -----------------------------------------------------------------------
    // NOTE: sequential state is assigned with <= so every register samples
    // pre-edge values, independent of statement order in the block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= 4'b0000;
        end else begin
            if (wr_nz) begin
                flags_q[N_IDX] <= bus.alu_flags[N_IDX];
                flags_q[Z_IDX] <= bus.alu_flags[Z_IDX];
            end
            if (wr_cv) begin
                flags_q[C_IDX] <= bus.alu_flags[C_IDX];
                flags_q[V_IDX] <= bus.alu_flags[V_IDX];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Writeback stage register. Flush wins over stall; a stall without flush
    // freezes the stage; an empty, unstalled cycle drains it.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            pcs_q     <= 1'b0;
            reg_w_q   <= 1'b0;
            mem_w_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else if (bus.flush) begin
            valid_q   <= 1'b0;
            pcs_q     <= 1'b0;
            reg_w_q   <= 1'b0;
            mem_w_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else if (bus.stall) begin
            valid_q   <= valid_q;
            pcs_q     <= pcs_q;
            reg_w_q   <= reg_w_q;
            mem_w_q   <= mem_w_q;
            illegal_q <= illegal_q;
        end else if (bus.valid_in) begin
            valid_q   <= 1'b1;
            pcs_q     <= bus.pcs_in && pass;
            // compare-type ops never write the register file
            reg_w_q   <= bus.reg_w_in && !bus.no_write_in && pass;
            mem_w_q   <= bus.mem_w_in && pass;
            illegal_q <= illegal;
        end else begin
            valid_q   <= 1'b0;
            pcs_q     <= 1'b0;
            reg_w_q   <= 1'b0;
            mem_w_q   <= 1'b0;
            illegal_q <= 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // Instruction counters: every accepted instruction bumps exactly one of
    // them. Both wrap naturally at 2**CNT_W.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exec_q <= '0;
            skip_q <= '0;
        end else if (accept) begin
            if (pass) begin
                exec_q <= exec_q + 1'b1;
            end else begin
                skip_q <= skip_q + 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign bus.cond_ex_o = pass;
    assign bus.flags_o   = flags_q;
    assign bus.valid_o   = valid_q;
    assign bus.pcs_o     = pcs_q;
    assign bus.reg_w_o   = reg_w_q;
    assign bus.mem_w_o   = mem_w_q;
    assign bus.illegal_o = illegal_q;
    assign bus.exec_cnt  = exec_q;
    assign bus.skip_cnt  = skip_q;

endmodule : cond_flag_unit

// File: tb/tb_cond_flag_unit.sv
// ---------------------------------------------------------------------------
// tb_cond_flag_unit
//   Self-checking bench for cond_flag_unit: a directed vector table, a few
//   hand-written corner-case sequences (counter wrap, asynchronous reset
//   between edges) and a randomized phase against a behavioural model.
// ---------------------------------------------------------------------------
module tb_cond_flag_unit;

    localparam int CNT_W = 16;

    logic clk;
    logic rst_n;

    cond_flag_unit_if #(.CNT_W(CNT_W)) bus ();

    cond_flag_unit #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // -----------------------------------------------------------------------
    // Behavioural model. Conditions come in complementary pairs: cond[3:1]
    // picks a base test, cond[0] inverts it (AL inverted gives the illegal
    // never-pass code).
    // -----------------------------------------------------------------------
    function automatic logic model_pass(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v, base;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c[3:1])
            3'd0:    base = z;
            3'd1:    base = cy;
            3'd2:    base = n;
            3'd3:    base = v;
            3'd4:    base = cy & ~z;
            3'd5:    base = (n == v);
            3'd6:    base = ~z & (n == v);
            default: base = 1'b1;
        endcase
        return base ^ c[0];
    endfunction

    logic [3:0]  m_flags;
    logic [4:0]  m_wb;      // {valid, pcs, reg_w, mem_w, illegal}
    logic [15:0] m_exec;
    logic [15:0] m_skip;

    task automatic model_reset();
        m_flags = 4'h0; m_wb = 5'b0; m_exec = 16'h0; m_skip = 16'h0;
    endtask

    // Advance the model by one clock edge using the currently driven inputs.
    task automatic model_step();
        logic acc, p;
        acc = bus.valid_in & ~bus.stall & ~bus.flush;
        p   = model_pass(bus.cond, m_flags);
        if (bus.flush || (!bus.valid_in && !bus.stall))
            m_wb = 5'b0;
        else if (!bus.stall)
            m_wb = {1'b1, bus.pcs_in & p, bus.reg_w_in & ~bus.no_write_in & p,
                    bus.mem_w_in & p, bus.cond == 4'hF};
        if (acc) begin
            if (p) begin
                if (bus.flag_w[1]) m_flags[3:2] = bus.alu_flags[3:2];
                if (bus.flag_w[0]) m_flags[1:0] = bus.alu_flags[1:0];
                m_exec = m_exec + 16'd1;
            end else begin
                m_skip = m_skip + 16'd1;
            end
        end
    endtask

    function automatic logic [4:0] dut_wb();
        return {bus.valid_o, bus.pcs_o, bus.reg_w_o, bus.mem_w_o, bus.illegal_o};
    endfunction

    task automatic drive(input logic v, input logic s, input logic f, input logic [3:0] c,
                         input logic [3:0] a, input logic [1:0] fw, input logic p,
                         input logic rw, input logic mw, input logic nw);
        bus.valid_in = v; bus.stall = s; bus.flush = f; bus.cond = c;
        bus.alu_flags = a; bus.flag_w = fw; bus.pcs_in = p;
        bus.reg_w_in = rw; bus.mem_w_in = mw; bus.no_write_in = nw;
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive(0, 0, 0, 4'h0, 4'h0, 2'b00, 0, 0, 0, 0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    // -----------------------------------------------------------------------
    // Directed vector table
    // -----------------------------------------------------------------------
    typedef struct packed {
        logic        valid;
        logic        stall;
        logic        flush;
        logic [3:0]  cond;
        logic [3:0]  alu;
        logic [1:0]  fw;
        logic        pcs;
        logic        rw;
        logic        mw;
        logic        nw;
        logic        exp_cex;    // before the edge
        logic [4:0]  exp_wb;     // after the edge: {valid,pcs,reg,mem,illegal}
        logic [3:0]  exp_flags;
        logic [15:0] exp_exec;
        logic [15:0] exp_skip;
    } vec_t;

    localparam int NVEC = 14;
    vec_t vecs [NVEC];

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 4'h0, 4'h0, 2'b00, 0, 0, 0, 0);
        model_reset();

        //           v  s  f  cond   alu      fw     p  rw mw nw cex wb        flags    exec    skip
        vecs[0]  = '{1'b1,1'b0,1'b0,4'hE,4'b0100,2'b11,1'b0,1'b1,1'b0,1'b0,1'b1,5'b10100,4'b0100,16'd1,16'd0};
        vecs[1]  = '{1'b1,1'b0,1'b0,4'h1,4'b1000,2'b11,1'b0,1'b1,1'b1,1'b0,1'b0,5'b10000,4'b0100,16'd1,16'd1};
        vecs[2]  = '{1'b1,1'b0,1'b0,4'hE,4'b1000,2'b11,1'b0,1'b0,1'b0,1'b0,1'b1,5'b10000,4'b1000,16'd2,16'd1};
        vecs[3]  = '{1'b1,1'b0,1'b0,4'hB,4'b0011,2'b01,1'b0,1'b1,1'b0,1'b1,1'b1,5'b10000,4'b1011,16'd3,16'd1};
        vecs[4]  = '{1'b1,1'b0,1'b0,4'hA,4'b0000,2'b00,1'b1,1'b0,1'b0,1'b0,1'b1,5'b11000,4'b1011,16'd4,16'd1};
        vecs[5]  = '{1'b1,1'b1,1'b0,4'hE,4'b1111,2'b11,1'b0,1'b0,1'b0,1'b0,1'b1,5'b11000,4'b1011,16'd4,16'd1};
        vecs[6]  = vecs[5];
        vecs[7]  = vecs[5];
        vecs[8]  = '{1'b1,1'b1,1'b1,4'hE,4'b1111,2'b11,1'b0,1'b0,1'b0,1'b0,1'b1,5'b00000,4'b1011,16'd4,16'd1};
        vecs[9]  = '{1'b1,1'b0,1'b0,4'hF,4'b0000,2'b00,1'b1,1'b0,1'b0,1'b0,1'b0,5'b10001,4'b1011,16'd4,16'd2};
        vecs[10] = '{1'b0,1'b0,1'b0,4'hE,4'b1111,2'b11,1'b1,1'b1,1'b1,1'b0,1'b1,5'b00000,4'b1011,16'd4,16'd2};
        vecs[11] = '{1'b1,1'b0,1'b0,4'h8,4'b0100,2'b10,1'b0,1'b0,1'b1,1'b0,1'b1,5'b10010,4'b0111,16'd5,16'd2};
        vecs[12] = '{1'b1,1'b0,1'b0,4'hC,4'b0000,2'b11,1'b0,1'b1,1'b0,1'b0,1'b0,5'b10000,4'b0111,16'd5,16'd3};
        vecs[13] = '{1'b1,1'b0,1'b0,4'hD,4'b0000,2'b11,1'b0,1'b1,1'b0,1'b0,1'b1,5'b10100,4'b0000,16'd6,16'd3};

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_wb",    32'(dut_wb()),      32'h0);
        check("reset_flags", 32'(bus.flags_o),   32'h0);
        check("reset_exec",  32'(bus.exec_cnt),  32'h0);
        check("reset_skip",  32'(bus.skip_cnt),  32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            drive(vecs[i].valid, vecs[i].stall, vecs[i].flush, vecs[i].cond, vecs[i].alu,
                  vecs[i].fw, vecs[i].pcs, vecs[i].rw, vecs[i].mw, vecs[i].nw);
            #1;
            check($sformatf("vec%0d_cond_ex", i), 32'(bus.cond_ex_o), 32'(vecs[i].exp_cex));
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_wb", i),    32'(dut_wb()),     32'(vecs[i].exp_wb));
            check($sformatf("vec%0d_flags", i), 32'(bus.flags_o),  32'(vecs[i].exp_flags));
            check($sformatf("vec%0d_exec", i),  32'(bus.exec_cnt), 32'(vecs[i].exp_exec));
            check($sformatf("vec%0d_skip", i),  32'(bus.skip_cnt), 32'(vecs[i].exp_skip));
        end

        // ---- exec counter wrap: 65535 AL accepts reach all-ones, one more wraps
        do_reset();
        @(negedge clk);
        drive(1, 0, 0, 4'hE, 4'h0, 2'b00, 0, 0, 0, 0);
        repeat (65535) @(posedge clk);
        #1;
        check("wrap_exec_ffff", 32'(bus.exec_cnt), 32'h0000_FFFF);
        check("wrap_skip_zero", 32'(bus.skip_cnt), 32'h0);
        @(posedge clk);
        #1;
        check("wrap_exec_zero", 32'(bus.exec_cnt), 32'h0);

        // ---- asynchronous reset between edges with a live writeback stage
        @(negedge clk);
        drive(1, 0, 0, 4'hE, 4'b1111, 2'b11, 1, 1, 1, 0);
        @(posedge clk);
        #1;
        check("pre_rst_wb", 32'(dut_wb()), 32'b11110);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_wb",    32'(dut_wb()),     32'h0);
        check("async_rst_flags", 32'(bus.flags_o),  32'h0);
        check("async_rst_exec",  32'(bus.exec_cnt), 32'h0);
        check("async_rst_skip",  32'(bus.skip_cnt), 32'h0);
        @(negedge clk);
        drive(0, 0, 0, 4'h0, 4'h0, 2'b00, 0, 0, 0, 0);
        rst_n = 1'b1;
        model_reset();

        // ---- randomized phase against the behavioural model
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            drive($urandom_range(99) < 80, $urandom_range(99) < 20, $urandom_range(99) < 10,
                  4'($urandom), 4'($urandom), 2'($urandom), 1'($urandom),
                  1'($urandom), 1'($urandom), $urandom_range(99) < 25);
            #1;
            check("rnd_cond_ex", 32'(bus.cond_ex_o), 32'(model_pass(bus.cond, m_flags)));
            model_step();
            @(posedge clk);
            #1;
            check("rnd_wb",    32'(dut_wb()),     32'(m_wb));
            check("rnd_flags", 32'(bus.flags_o),  32'(m_flags));
            check("rnd_exec",  32'(bus.exec_cnt), 32'(m_exec));
            check("rnd_skip",  32'(bus.skip_cnt), 32'(m_skip));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_cond_flag_unit
